// File: rtl/track_control_core_if.sv
// Command handshake bundle for track_control_core: the host drives the command,
// the core answers with ready.
interface track_control_core_if #(
  parameter int N_TRACK = 8,
  parameter int TW      = $clog2(N_TRACK)
);
  logic               i_cmd_valid;
  logic [2:0]         i_cmd_op;
  logic [TW-1:0]      i_cmd_track;
  logic [N_TRACK-1:0] i_cmd_mask;
  logic [4:0]         i_pitch_cfg;
  logic               o_cmd_ready;

  modport master (output i_cmd_valid, i_cmd_op, i_cmd_track, i_cmd_mask, i_pitch_cfg,
                  input  o_cmd_ready);
  modport slave  (input  i_cmd_valid, i_cmd_op, i_cmd_track, i_cmd_mask, i_pitch_cfg,
                  output o_cmd_ready);
endinterface

// File: rtl/track_control_core.sv
// Track control core: sequences SRAM track load, play, record, mix and pitch engines.
// Define CC_TIMEOUT_EN to add the MIX/PITCH watchdog (limit TIMEOUT_CYC cycles).
module track_control_core #(
  parameter int          N_TRACK     = 8,
  parameter int          AW          = 23,
  parameter logic [23:0] TIMEOUT_CYC = 24'd12_000_000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  track_control_core_if.slave cmd,
  input  logic                i_load_done,
  output logic                o_play_start,
  output logic                o_play_pause,
  output logic                o_play_stop,
  input  logic                i_play_done,
  output logic [AW-1:0]       o_play_addr,
  output logic                o_rec_start,
  output logic                o_rec_pause,
  output logic                o_rec_stop,
  input  logic                i_rec_done,
  output logic [AW-1:0]       o_rec_addr,
  output logic                o_mix_start,
  output logic [N_TRACK-1:0]  o_mix_mask,
  output logic [AW-1:0]       o_mix_dst_addr,
  input  logic                i_mix_done,
  output logic                o_pitch_start,
  output logic [AW-1:0]       o_pitch_src_addr,
  output logic [AW-1:0]       o_pitch_dst_addr,
  output logic [4:0]          o_pitch_cfg,
  input  logic                i_pitch_done,
  output logic [2:0]          o_state,
  output logic [N_TRACK-1:0]  o_track_valid,
  output logic                o_err
);
  localparam int TW = $clog2(N_TRACK);

  if (N_TRACK < 2 || N_TRACK > 16 || (N_TRACK & (N_TRACK - 1)) != 0 || TIMEOUT_CYC == 24'd0)
  begin : g_bad_cfg
    $error("track_control_core: unsupported N_TRACK or TIMEOUT_CYC");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0, LOAD = 3'd1, MIX = 3'd2, PITCH = 3'd3,
    PLAY = 3'd4, RECORD = 3'd5, STOPWAIT = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0, OP_PLAY = 3'd1, OP_RECORD = 3'd2, OP_MIX = 3'd3,
    OP_PITCH = 3'd4, OP_PAUSE = 3'd5, OP_STOP = 3'd6, OP_RSVD = 3'd7
  } op_e;

  function automatic logic [AW-1:0] base_addr(input logic [TW-1:0] t);
    return {t, {(AW-TW){1'b0}}};
  endfunction

  state_e             state, state_d;
  op_e                op;
  logic               ready, accept, stop_rec, stop_rec_d;
  logic               play_start_d, play_pause_d, play_stop_d;
  logic               rec_start_d, rec_pause_d, rec_stop_d;
  logic               mix_start_d, pitch_start_d, err_d;
  logic [AW-1:0]      play_addr_d, rec_addr_d, mix_dst_addr_d, pitch_src_addr_d, pitch_dst_addr_d;
  logic [N_TRACK-1:0] mix_mask_d, track_valid_d;
  logic [4:0]         pitch_cfg_d;
  logic [TW-1:0]      low_trk, rec_trk, mix_trk, pitch_trk;

`ifdef CC_TIMEOUT_EN
  logic [23:0] wd_cnt, wd_cnt_d;
  logic        wd_hit;
  assign wd_hit = (wd_cnt == TIMEOUT_CYC - 24'd1);
`endif

  assign op              = op_e'(cmd.i_cmd_op);
  assign ready           = (state == IDLE) || (state == PLAY) || (state == RECORD);
  assign cmd.o_cmd_ready = ready;
  assign accept          = cmd.i_cmd_valid & ready;
  assign o_state         = state;
  // Destination slots are recovered from the held addresses rather than kept twice.
  assign rec_trk         = o_rec_addr[AW-1 -: TW];
  assign mix_trk         = o_mix_dst_addr[AW-1 -: TW];
  assign pitch_trk       = o_pitch_dst_addr[AW-1 -: TW];

  always_comb begin
    low_trk = '0;
    for (int unsigned i = N_TRACK; i > 0; i--)
      if (cmd.i_cmd_mask[i-1]) low_trk = TW'(i - 1);
  end

  always_comb begin
    state_d          = state;
    play_start_d     = 1'b0;
    play_stop_d      = 1'b0;
    rec_start_d      = 1'b0;
    rec_stop_d       = 1'b0;
    mix_start_d      = 1'b0;
    pitch_start_d    = 1'b0;
    err_d            = 1'b0;
    play_pause_d     = o_play_pause;
    rec_pause_d      = o_rec_pause;
    play_addr_d      = o_play_addr;
    rec_addr_d       = o_rec_addr;
    mix_mask_d       = o_mix_mask;
    mix_dst_addr_d   = o_mix_dst_addr;
    pitch_src_addr_d = o_pitch_src_addr;
    pitch_dst_addr_d = o_pitch_dst_addr;
    pitch_cfg_d      = o_pitch_cfg;
    track_valid_d    = o_track_valid;
    stop_rec_d       = stop_rec;
`ifdef CC_TIMEOUT_EN
    wd_cnt_d         = wd_cnt + 24'd1;
`endif
    case (state)
      LOAD: if (i_load_done) begin
        state_d       = IDLE;
        track_valid_d = '1;
      end
      IDLE: if (accept) begin
        case (op)
          OP_NOP: begin end
          OP_PLAY:
            if (o_track_valid[cmd.i_cmd_track]) begin
              state_d      = PLAY;
              play_start_d = 1'b1;
              play_addr_d  = base_addr(cmd.i_cmd_track);
            end else err_d = 1'b1;
          OP_RECORD: begin
            state_d                          = RECORD;
            rec_start_d                      = 1'b1;
            rec_addr_d                       = base_addr(cmd.i_cmd_track);
            track_valid_d[cmd.i_cmd_track]   = 1'b0;
          end
          OP_MIX:
            if (cmd.i_cmd_mask != '0 && (cmd.i_cmd_mask & ~o_track_valid) == '0) begin
              state_d        = MIX;
              mix_start_d    = 1'b1;
              mix_mask_d     = cmd.i_cmd_mask;
              mix_dst_addr_d = base_addr(cmd.i_cmd_track);
`ifdef CC_TIMEOUT_EN
              wd_cnt_d       = '0;
`endif
            end else err_d = 1'b1;
          OP_PITCH:
            if (o_track_valid[cmd.i_cmd_track] && cmd.i_cmd_mask != '0) begin
              state_d          = PITCH;
              pitch_start_d    = 1'b1;
              pitch_src_addr_d = base_addr(cmd.i_cmd_track);
              pitch_dst_addr_d = base_addr(low_trk);
              pitch_cfg_d      = cmd.i_pitch_cfg;
`ifdef CC_TIMEOUT_EN
              wd_cnt_d         = '0;
`endif
            end else err_d = 1'b1;
          default: err_d = 1'b1;
        endcase
      end
      // A done in the same cycle as a command takes priority over it.
      PLAY:
        if (i_play_done) begin
          state_d      = IDLE;
          play_pause_d = 1'b0;
        end else if (accept) begin
          case (op)
            OP_NOP:   begin end
            OP_PAUSE: play_pause_d = ~o_play_pause;
            OP_STOP: begin
              state_d      = STOPWAIT;
              play_stop_d  = 1'b1;
              play_pause_d = 1'b0;
              stop_rec_d   = 1'b0;
            end
            default:  err_d = 1'b1;
          endcase
        end
      RECORD:
        if (i_rec_done) begin
          state_d                = IDLE;
          rec_pause_d            = 1'b0;
          track_valid_d[rec_trk] = 1'b1;
        end else if (accept) begin
          case (op)
            OP_NOP:   begin end
            OP_PAUSE: rec_pause_d = ~o_rec_pause;
            OP_STOP: begin
              state_d     = STOPWAIT;
              rec_stop_d  = 1'b1;
              rec_pause_d = 1'b0;
              stop_rec_d  = 1'b1;
            end
            default:  err_d = 1'b1;
          endcase
        end
      MIX:
        if (i_mix_done) begin
          state_d                = IDLE;
          track_valid_d[mix_trk] = 1'b1;
        end
`ifdef CC_TIMEOUT_EN
        else if (wd_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
`endif
      PITCH:
        if (i_pitch_done) begin
          state_d                  = IDLE;
          track_valid_d[pitch_trk] = 1'b1;
        end
`ifdef CC_TIMEOUT_EN
        else if (wd_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
`endif
      STOPWAIT:
        if (stop_rec ? i_rec_done : i_play_done) begin
          state_d = IDLE;
          if (stop_rec) track_valid_d[rec_trk] = 1'b1;
        end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state            <= LOAD;
      o_play_start     <= 1'b0;
      o_play_pause     <= 1'b0;
      o_play_stop      <= 1'b0;
      o_rec_start      <= 1'b0;
      o_rec_pause      <= 1'b0;
      o_rec_stop       <= 1'b0;
      o_mix_start      <= 1'b0;
      o_pitch_start    <= 1'b0;
      o_err            <= 1'b0;
      o_play_addr      <= '0;
      o_rec_addr       <= '0;
      o_mix_mask       <= '0;
      o_mix_dst_addr   <= '0;
      o_pitch_src_addr <= '0;
      o_pitch_dst_addr <= '0;
      o_pitch_cfg      <= '0;
      o_track_valid    <= '0;
      stop_rec         <= 1'b0;
`ifdef CC_TIMEOUT_EN
      wd_cnt           <= '0;
`endif
    end else begin
      state            <= state_d;
      o_play_start     <= play_start_d;
      o_play_pause     <= play_pause_d;
      o_play_stop      <= play_stop_d;
      o_rec_start      <= rec_start_d;
      o_rec_pause      <= rec_pause_d;
      o_rec_stop       <= rec_stop_d;
      o_mix_start      <= mix_start_d;
      o_pitch_start    <= pitch_start_d;
      o_err            <= err_d;
      o_play_addr      <= play_addr_d;
      o_rec_addr       <= rec_addr_d;
      o_mix_mask       <= mix_mask_d;
      o_mix_dst_addr   <= mix_dst_addr_d;
      o_pitch_src_addr <= pitch_src_addr_d;
      o_pitch_dst_addr <= pitch_dst_addr_d;
      o_pitch_cfg      <= pitch_cfg_d;
      o_track_valid    <= track_valid_d;
      stop_rec         <= stop_rec_d;
`ifdef CC_TIMEOUT_EN
      wd_cnt           <= wd_cnt_d;
`endif
    end
  end
endmodule
